// File: rtl/v2_filter_ctrl_pkg.sv
// v2_param: shared state, event type and default timing constants for the filter controller
package v2_param;
  localparam int V2_WIDTH      = 16;
  localparam int V2_CLR_CYC    = 4;
  localparam int V2_PEAK_DLY   = 8;
  localparam int V2_HOLDOFF    = 32;
  localparam int V2_FIFO_DEPTH = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, ARMED, RISE, HOLD} state_t;
  typedef struct packed {
    logic                pileup;
    logic [V2_WIDTH-1:0] peak;
    logic [31:0]         ts;
  } evt_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/v2_filter_ctrl_if.sv
// v2_filter_ctrl_if: event handshake bundle between the controller and its consumer
interface v2_filter_ctrl_if #(parameter int WIDTH = v2_param::V2_WIDTH);
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_pileup;
  logic [WIDTH-1:0] evt_peak;
  logic [31:0]      evt_ts;
  modport master (output evt_valid, evt_peak, evt_ts, evt_pileup, input evt_ready);
  modport slave (input evt_valid, evt_peak, evt_ts, evt_pileup, output evt_ready);
endinterface

// File: rtl/v2_filter_ctrl_evt_fifo.sv
// v2_evt_fifo: small event buffer; head reads as zero while empty, full push accepted only alongside a pop
module v2_evt_fifo
  import v2_param::*;
#(
  parameter type T     = evt_t,
  parameter int  DEPTH = V2_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic ready,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic pop, put;
  assign empty = cnt == '0;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign pop   = !empty && ready;
  assign put   = push && (!full || pop);
  assign dout  = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (put) mem[wr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      rd  <= pop ? rd + 1'b1 : rd;
      wr  <= put ? wr + 1'b1 : wr;
      cnt <= cnt + (AW+1)'(put) - (AW+1)'(pop);
    end
endmodule

// File: rtl/v2_filter_ctrl.sv
// v2_filter_ctrl: threshold trigger, delayed peak capture, hold-off pile-up detection and event buffering
module v2_filter_ctrl
  import v2_param::*;
#(
  parameter int WIDTH      = V2_WIDTH,
  parameter int CLR_CYC    = V2_CLR_CYC,
  parameter int PEAK_DLY   = V2_PEAK_DLY,
  parameter int HOLDOFF    = V2_HOLDOFF,
  parameter int FIFO_DEPTH = V2_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] flt_in,
  output logic             flt_clr_n,
  output logic             busy,
  output logic             overflow,
  output logic [15:0]      pileup_cnt,
  output logic [15:0]      drop_cnt,
  v2_filter_ctrl_if.master evt
);
  typedef struct packed {
    logic             pileup;
    logic [WIDTH-1:0] peak;
    logic [31:0]      ts;
  } ev_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [31:0] ts, ts_lat;
  logic [WIDTH-1:0] peak;
  logic seen_low, pile, above, pile_set, push, drop, full, empty;
  ev_t din, head;
  assign above    = flt_in > threshold;
  assign pile_set = state == HOLD && seen_low && above && !pile;
  assign push     = enable && state == HOLD && cnt == 16'(HOLDOFF - 1);
  assign drop     = push && full && !(!empty && evt.evt_ready);
  assign din      = '{pileup: pile || pile_set, peak: peak, ts: ts_lat};
  always_comb
    nxt = !enable        ? IDLE :
          state == IDLE  ? CLEAR :
          state == CLEAR ? (cnt == 16'(CLR_CYC - 1) ? ARMED : CLEAR) :
          state == ARMED ? (above ? RISE : ARMED) :
          state == RISE  ? (!above ? ARMED : cnt == 16'(PEAK_DLY - 1) ? HOLD : RISE) :
          state == HOLD  ? (cnt == 16'(HOLDOFF - 1) ? CLEAR : HOLD) : IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ts         <= '0;
      ts_lat     <= '0;
      peak       <= '0;
      seen_low   <= 1'b0;
      pile       <= 1'b0;
      flt_clr_n  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      pileup_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state     <= nxt;
      cnt       <= nxt == state ? cnt + 16'd1 : '0;
      ts        <= ts + 32'd1;
      flt_clr_n <= nxt inside {ARMED, RISE, HOLD};
      busy      <= nxt inside {CLEAR, RISE, HOLD};
      if (state == ARMED && above) begin
        ts_lat <= ts;
        peak   <= flt_in;
      end else if (state == RISE && flt_in > peak) peak <= flt_in;
      // seen_low only remembers lows from earlier cycles of the same hold window
      seen_low   <= state == HOLD && (seen_low || !above);
      pile       <= state == HOLD && (pile || pile_set);
      pileup_cnt <= pile_set ? sat_inc(pileup_cnt) : pileup_cnt;
      overflow   <= overflow || drop;
      drop_cnt   <= drop ? sat_inc(drop_cnt) : drop_cnt;
    end
  v2_evt_fifo #(.T(ev_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .ready (evt.evt_ready),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign evt.evt_valid  = !empty;
  assign evt.evt_peak   = head.peak;
  assign evt.evt_ts     = head.ts;
  assign evt.evt_pileup = head.pileup;
endmodule

// File: tb/tb_v2_filter_ctrl.sv
// tb_v2_filter_ctrl: directed scenarios checked against a sample-array event model
module tb_v2_filter_ctrl;
  localparam int CLR = 4, PDLY = 8, HOLD = 32, THR = 100;
  typedef struct {int peak; int ts; bit pileup;} ev_s;
  logic clk = 0, reset = 0, enable = 0;
  logic [15:0] threshold = 16'(THR), flt_in = '0;
  logic flt_clr_n, busy, overflow;
  logic [15:0] pileup_cnt, drop_cnt;
  int tests = 0, fails = 0, exp_pile = 0, clr_low = 0;
  bit stall = 0;
  logic [15:0] p_peak;
  logic [31:0] p_ts;
  logic p_pile;
  ev_s exp_q[$], rx_q[$], e;
  logic [15:0] stim[$];
  v2_filter_ctrl_if #(.WIDTH(16)) evt_if ();
  v2_filter_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .flt_in(flt_in),
    .flt_clr_n(flt_clr_n), .busy(busy), .overflow(overflow),
    .pileup_cnt(pileup_cnt), .drop_cnt(drop_cnt), .evt(evt_if)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  // Expected events straight from the trigger/peak/hold rules applied to the whole sample array
  function automatic void model();
    int n = stim.size();
    int i = CLR + 1;
    int low_at, pk;
    bit seen, pu;
    exp_q = {};
    exp_pile = 0;
    while (i + PDLY + HOLD < n) begin
      if (stim[i] <= THR) begin
        i++;
        continue;
      end
      low_at = 0;
      for (int d = 1; d <= PDLY; d++) if (low_at == 0 && stim[i+d] <= THR) low_at = i + d;
      if (low_at != 0) begin
        i = low_at + 1;
        continue;
      end
      pk = 0;
      for (int d = 0; d <= PDLY; d++) if (int'(stim[i+d]) > pk) pk = int'(stim[i+d]);
      seen = 0;
      pu = 0;
      for (int h = i + PDLY + 1; h <= i + PDLY + HOLD; h++)
        if (stim[h] <= THR) seen = 1;
        else if (seen) pu = 1;
      exp_q.push_back('{pk, i, pu});
      exp_pile += int'(pu);
      i += PDLY + HOLD + CLR + 1;
    end
  endfunction
  // Single compare process: handshakes against the model, stall stability, clear-length tally
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (stall) begin
        check("stall_valid", evt_if.evt_valid, 1);
        check("stall_peak", evt_if.evt_peak, p_peak);
        check("stall_ts", evt_if.evt_ts, p_ts);
        check("stall_pileup", evt_if.evt_pileup, p_pile);
      end
      if (busy && !flt_clr_n) clr_low++;
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        rx_q.push_back('{int'(evt_if.evt_peak), int'(evt_if.evt_ts), evt_if.evt_pileup});
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_evt: got ts %0d peak %0d, required no event", evt_if.evt_ts, evt_if.evt_peak);
        end else begin
          e = exp_q.pop_front();
          check("evt_peak", evt_if.evt_peak, e.peak);
          check("evt_ts", evt_if.evt_ts, e.ts);
          check("evt_pileup", evt_if.evt_pileup, e.pileup);
        end
      end
      stall = evt_if.evt_valid && !evt_if.evt_ready;
      p_peak = evt_if.evt_peak;
      p_ts = evt_if.evt_ts;
      p_pile = evt_if.evt_pileup;
    end else stall = 0;
  end
  task automatic rst_checks(input string tag);
    check({tag, "_clr_n"}, flt_clr_n, 0);
    check({tag, "_valid"}, evt_if.evt_valid, 0);
    check({tag, "_peak"}, evt_if.evt_peak, 0);
    check({tag, "_ts"}, evt_if.evt_ts, 0);
    check({tag, "_pileup"}, evt_if.evt_pileup, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_pileup_cnt"}, pileup_cnt, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask
  task automatic blank(input int len);
    stim = {};
    repeat (len) stim.push_back('0);
  endtask
  task automatic fill(input int at, input int n, input int val);
    for (int j = 0; j < n; j++) stim[at+j] = 16'(val);
  endtask
  task automatic setv(input int at, input int v[$]);
    foreach (v[j]) stim[at+j] = 16'(v[j]);
  endtask
  task automatic run(input int rdy_low, input int probe_k, input logic probe_busy, input int reset_k, input int exp_drops);
    reset = 0;
    enable = 0;
    evt_if.evt_ready = 0;
    flt_in = '0;
    #1;
    rst_checks("rst");
    clr_low = 0;
    rx_q = {};
    @(negedge clk);
    enable = 1;
    flt_in = stim[0];
    evt_if.evt_ready = rdy_low == 0;
    reset = 1;
    for (int k = 1; k < stim.size(); k++) begin
      @(posedge clk);
      #1;
      flt_in = stim[k];
      evt_if.evt_ready = k >= rdy_low;
      if (k == 8) begin
        check("clear_len", clr_low, CLR);
        check("clr_n_after_clear", flt_clr_n, 1);
        check("valid_after_clear", evt_if.evt_valid, 0);
      end
      if (k == probe_k) check("busy_probe", busy, probe_busy);
      if (k == reset_k) begin
        check("pre_rst_valid", evt_if.evt_valid, 1);
        reset = 0;
        #1;
        rst_checks("midrst");
        exp_q = {};
        exp_pile = 0;
        @(negedge clk);
        reset = 1;
      end
    end
    check("drop_cnt", drop_cnt, exp_drops);
    check("overflow", overflow, exp_drops > 0);
    check("pileup_cnt", pileup_cnt, exp_pile);
    check("undelivered", exp_q.size(), exp_drops);
  endtask
  initial begin
    evt_if.evt_ready = 0;
    blank(80);
    setv(10, {200, 350, 500, 480, 400, 330, 270, 220, 180, 90, 60, 40});
    model();
    check("model_ramp_n", exp_q.size(), 1);
    check("model_ramp_peak", exp_q[0].peak, 500);
    check("model_ramp_ts", exp_q[0].ts, 10);
    run(0, 12, 1'b1, -1, 0);
    check("ramp_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) begin
      check("ramp_rx_peak", rx_q[0].peak, 500);
      check("ramp_rx_ts", rx_q[0].ts, 10);
      check("ramp_rx_pileup", rx_q[0].pileup, 0);
    end
    blank(100);
    fill(0, 30, 100);
    setv(30, {150, 150, 150, 50});
    fill(40, 9, 300);
    model();
    check("model_abort_n", exp_q.size(), 1);
    check("model_abort_ts", exp_q[0].ts, 40);
    run(0, 36, 1'b0, -1, 0);
    check("abort_rx_n", rx_q.size(), 1);
    blank(100);
    fill(10, 9, 300);
    stim[25] = 16'd50;
    stim[30] = 16'd300;
    model();
    check("model_pile", exp_q[0].pileup, 1);
    run(0, -1, 1'b0, -1, 0);
    check("pile_cnt_lit", pileup_cnt, 1);
    check("pile_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check("pile_rx_flag", rx_q[0].pileup, 1);
    blank(300);
    for (int j = 0; j < 5; j++) begin
      fill(5 + 45 * j, 9, 200);
      stim[5+45*j+3] = 16'(400 + j);
    end
    model();
    check("model_ovf_n", exp_q.size(), 5);
    check("model_ovf_ts4", exp_q[4].ts, 185);
    run(240, 100, 1'b1, -1, 1);
    check("ovf_rx_n", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      check("ovf_first_peak", rx_q[0].peak, 400);
      check("ovf_last_peak", rx_q[3].peak, 403);
    end
    blank(150);
    fill(5, 9, 300);
    fill(55, 4, 300);
    model();
    run(58, 58, 1'b1, 58, 0);
    check("rst_rx_n", rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/v2_filter_ctrl.md
V2_FILTER_CTRL -- requirements
Module: v2_filter_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default V2_WIDTH, sample/peak width; CLR_CYC, default 4, filter-clear length in cycles; PEAK_DLY, default 8, cycles from trigger to peak capture; HOLDOFF, default 32, dead-time cycles after capture; FIFO_DEPTH, default 4, event buffer depth (power of two).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  run request; low parks the block in IDLE.
REQ-005 threshold  input  WIDTH  unsigned trigger level.
REQ-006 flt_in  input  WIDTH  unsigned filter output sample, one per cycle.
REQ-007 flt_clr_n  output  1  drives the filter's active-low clear; 0 clears the filter.
REQ-008 evt_valid / evt_ready  output / input  1 / 1  event handshake.
REQ-009 evt_peak, evt_ts, evt_pileup  output  WIDTH, 32, 1  head-of-buffer event fields.
REQ-010 busy  output  1  high in any state except IDLE and ARMED.
REQ-011 overflow  output  1  sticky, event dropped on full buffer.
REQ-012 pileup_cnt, drop_cnt  output  16, 16  saturating counters.

Function
REQ-013 States SHALL be IDLE, CLEAR, ARMED, RISE, HOLD; encoding is free.
REQ-014 IDLE: flt_clr_n=0; when enable=1, go to CLEAR next cycle.
REQ-015 CLEAR: flt_clr_n=0 for exactly CLR_CYC cycles, then ARMED; flt_clr_n=1 in every other state except IDLE.
REQ-016 ARMED: flt_in > threshold (strict) -> RISE; latch ts counter value of that cycle; peak register = flt_in; delay counter = 0.
REQ-017 RISE: peak register = max(peak, flt_in) each cycle; if flt_in <= threshold before PEAK_DLY cycles elapse -> ARMED, no event; after PEAK_DLY cycles -> HOLD.
REQ-018 HOLD: lasts HOLDOFF cycles; pileup flag sets if flt_in goes <= threshold and later > threshold again within HOLD; each set flag increments pileup_cnt once.
REQ-019 At HOLD exit, event {peak, ts, pileup flag} SHALL be pushed to the buffer; next state CLEAR.
REQ-020 enable=0 in any state -> IDLE next cycle; in-flight event discarded; buffered events retained.
REQ-021 Timestamp: 32-bit free-running counter, +1 per cycle from reset release, wraps 0xFFFFFFFF -> 0.
REQ-022 Buffer: FIFO order; evt_valid=1 when non-empty; pop on evt_valid&&evt_ready; outputs stable while evt_valid&&!evt_ready; a pushed event is visible at evt_valid one cycle after push.
REQ-023 Push when full SHALL drop the event, set overflow, increment drop_cnt; push when full with a pop in the same cycle SHALL be accepted.
REQ-024 pileup_cnt and drop_cnt SHALL saturate at 0xFFFF.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, flt_clr_n=0, evt_valid=0, evt_peak=0, evt_ts=0, evt_pileup=0, busy=0, overflow=0, counters 0, ts 0, buffer empty.
REQ-026 overflow SHALL clear only on reset.

Structure
REQ-027 v2_param SHALL hold the state enum, event struct type (pileup, peak, ts), and the default CLR_CYC/PEAK_DLY/HOLDOFF/FIFO_DEPTH constants.
REQ-028 The buffer SHALL be sub-module v2_evt_fifo (event struct, depth parameter, valid/ready, full/empty).

Verification (WIDTH=16, threshold=100, defaults)
REQ-029 Reset release, enable=1 -> flt_clr_n=0 exactly 4 cycles then 1; evt_valid stays 0.
REQ-030 Ramp 0,200,350,500,480,... decaying below 100 before HOLD end, evt_ready=1 -> one event peak=500, pileup=0, ts=cycle of 200 sample.
REQ-031 flt_in=100 constant -> no trigger; 150 for 3 cycles then 50 -> no event, returns ARMED.
REQ-032 Second crossing (50 then 300) inside HOLD -> evt_pileup=1, pileup_cnt=1.
REQ-033 evt_ready=0, five pulses -> four buffered, overflow=1, drop_cnt=1; then evt_ready=1 drains four in order.
REQ-034 reset=0 mid-RISE -> all outputs at reset values same cycle; after release no event emitted.
